// File: rtl/axi_sink_txn_ctrl.sv
// AXI4 sink transaction controller.
// Bounds the number of outstanding write and read bursts by gating the
// AW/AR valid/ready pairs, and offers a quiesce/drain handshake so the
// shell can safely reconfigure or reset the downstream data path.
// B and R channels are observed only; payloads never pass through here.
module axi_sink_txn_ctrl #(
    parameter int MAX_WR   = 16,
    parameter int MAX_RD   = 16,
    parameter int CNT_BITS = 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    // write address gating
    input  logic                s_awvalid,
    output logic                s_awready,
    output logic                m_awvalid,
    input  logic                m_awready,
    // read address gating
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic                m_arvalid,
    input  logic                m_arready,
    // observed response/data handshakes
    input  logic                bvalid,
    input  logic                bready,
    input  logic                rvalid,
    input  logic                rready,
    input  logic                rlast,
    // quiesce handshake and status
    input  logic                quiesce_req,
    output logic                quiesce_ack,
    output logic [CNT_BITS-1:0] wr_outstanding,
    output logic [CNT_BITS-1:0] rd_outstanding,
    output logic                err_underflow
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_IDLE  = 2'd2;

    localparam logic [CNT_BITS-1:0] WR_LIMIT = CNT_BITS'(MAX_WR);
    localparam logic [CNT_BITS-1:0] RD_LIMIT = CNT_BITS'(MAX_RD);

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic [CNT_BITS-1:0] wr_cnt;
    logic [CNT_BITS-1:0] rd_cnt;
    logic [CNT_BITS-1:0] wr_cnt_next;
    logic [CNT_BITS-1:0] rd_cnt_next;
    logic                wr_uf;
    logic                rd_uf;
    logic                ack_q;
    logic                err_q;

    logic                wr_en;
    logic                rd_en;
    logic                aw_hs;
    logic                ar_hs;
    logic                b_hs;
    logic                r_last_hs;

    // Enables depend only on registered state and counts, so the
    // valid/ready gating never forms a combinational loop and a burst
    // can never push a counter past its limit.
    assign wr_en = (state == ST_RUN) && (wr_cnt < WR_LIMIT);
    assign rd_en = (state == ST_RUN) && (rd_cnt < RD_LIMIT);

    assign m_awvalid = s_awvalid & wr_en;
    assign s_awready = m_awready & wr_en;
    assign m_arvalid = s_arvalid & rd_en;
    assign s_arready = m_arready & rd_en;

    assign aw_hs     = m_awvalid & m_awready;
    assign ar_hs     = m_arvalid & m_arready;
    assign b_hs      = bvalid & bready;
    assign r_last_hs = rvalid & rready & rlast;

    // Next write count: +1 per accepted AW, -1 per accepted B, saturating at 0.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        wr_cnt_next = wr_cnt;
        wr_uf       = 1'b0;
        if (aw_hs && !b_hs) begin
            wr_cnt_next = wr_cnt + 1'b1;
        end else if (b_hs && !aw_hs) begin
            if (wr_cnt == '0) begin
                wr_uf = 1'b1;
            end else begin
                wr_cnt_next = wr_cnt - 1'b1;
            end
        end
    end

    // Next read count: +1 per accepted AR, -1 per accepted last R beat.
    always_comb begin
        rd_cnt_next = rd_cnt;
        rd_uf       = 1'b0;
        if (ar_hs && !r_last_hs) begin
            rd_cnt_next = rd_cnt + 1'b1;
        end else if (r_last_hs && !ar_hs) begin
            if (rd_cnt == '0) begin
                rd_uf = 1'b1;
            end else begin
                rd_cnt_next = rd_cnt - 1'b1;
            end
        end
    end

    // Quiesce FSM: a dropped request always wins and returns to RUN;
    // the drain completes only on registered zero counts.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (quiesce_req) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!quiesce_req) begin
                    state_next = ST_RUN;
                end else if ((wr_cnt == '0) && (rd_cnt == '0)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!quiesce_req) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    // State, counters, acknowledge and sticky underflow flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= ST_RUN;
            wr_cnt <= '0;
            rd_cnt <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, independent of statement order.
            state  <= state_next;
            wr_cnt <= wr_cnt_next;
            rd_cnt <= rd_cnt_next;
            ack_q  <= (state_next == ST_IDLE);
            if (wr_uf || rd_uf) err_q <= 1'b1;
        end
    end

    assign quiesce_ack    = ack_q;
    assign wr_outstanding = wr_cnt;
    assign rd_outstanding = rd_cnt;
    assign err_underflow  = err_q;

endmodule

// File: tb/tb_axi_sink_txn_ctrl.sv
// Self-checking bench for axi_sink_txn_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model built from outstanding-count arithmetic.
module tb_axi_sink_txn_ctrl;

    localparam int MAX_WR   = 4;
    localparam int MAX_RD   = 4;
    localparam int CNT_BITS = 8;

    localparam int MD_RUN   = 0;
    localparam int MD_DRAIN = 1;
    localparam int MD_IDLE  = 2;

    logic                aclk = 1'b0;
    logic                aresetn = 1'b0;
    logic                s_awvalid = 1'b0, m_awready = 1'b0;
    logic                s_arvalid = 1'b0, m_arready = 1'b0;
    logic                bvalid = 1'b0, bready = 1'b0;
    logic                rvalid = 1'b0, rready = 1'b0, rlast = 1'b0;
    logic                quiesce_req = 1'b0;
    logic                s_awready, m_awvalid, s_arready, m_arvalid;
    logic                quiesce_ack, err_underflow;
    logic [CNT_BITS-1:0] wr_outstanding, rd_outstanding;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    axi_sink_txn_ctrl #(
        .MAX_WR  (MAX_WR),
        .MAX_RD  (MAX_RD),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_awvalid     (s_awvalid),
        .s_awready     (s_awready),
        .m_awvalid     (m_awvalid),
        .m_awready     (m_awready),
        .s_arvalid     (s_arvalid),
        .s_arready     (s_arready),
        .m_arvalid     (m_arvalid),
        .m_arready     (m_arready),
        .bvalid        (bvalid),
        .bready        (bready),
        .rvalid        (rvalid),
        .rready        (rready),
        .rlast         (rlast),
        .quiesce_req   (quiesce_req),
        .quiesce_ack   (quiesce_ack),
        .wr_outstanding(wr_outstanding),
        .rd_outstanding(rd_outstanding),
        .err_underflow (err_underflow)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_wr   = 0;
    int m_rd   = 0;
    int m_mode = MD_RUN;
    bit m_err  = 1'b0;

    // New address bursts are admitted only while running and below the limit.
    wire exp_wr_en = (m_mode == MD_RUN) && (m_wr < MAX_WR);
    wire exp_rd_en = (m_mode == MD_RUN) && (m_rd < MAX_RD);
    wire mdl_aw    = s_awvalid && m_awready && exp_wr_en;
    wire mdl_ar    = s_arvalid && m_arready && exp_rd_en;
    wire mdl_b     = bvalid && bready;
    wire mdl_rl    = rvalid && rready && rlast;

    function automatic int clamp0(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_wr   <= 0;
            m_rd   <= 0;
            m_mode <= MD_RUN;
            m_err  <= 1'b0;
        end else begin
            m_wr <= clamp0(m_wr + int'(mdl_aw) - int'(mdl_b));
            m_rd <= clamp0(m_rd + int'(mdl_ar) - int'(mdl_rl));
            if ((m_wr + int'(mdl_aw) - int'(mdl_b) < 0) ||
                (m_rd + int'(mdl_ar) - int'(mdl_rl) < 0)) m_err <= 1'b1;
            if (!quiesce_req)                 m_mode <= MD_RUN;
            else if (m_mode == MD_RUN)        m_mode <= MD_DRAIN;
            else if (m_wr == 0 && m_rd == 0)  m_mode <= MD_IDLE;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge aclk) begin
        if (chk_en) begin
            check("cmp_m_awvalid", m_awvalid, s_awvalid && exp_wr_en);
            check("cmp_s_awready", s_awready, m_awready && exp_wr_en);
            check("cmp_m_arvalid", m_arvalid, s_arvalid && exp_rd_en);
            check("cmp_s_arready", s_arready, m_arready && exp_rd_en);
            check("cmp_wr_cnt", wr_outstanding, m_wr);
            check("cmp_rd_cnt", rd_outstanding, m_rd);
            check("cmp_ack", quiesce_ack, m_mode == MD_IDLE);
            check("cmp_err", err_underflow, m_err);
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int ph, pa, pb, pr;

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        chk_en = 1'b1;
        #1;
        check("rst_wr", wr_outstanding, 0);
        check("rst_rd", rd_outstanding, 0);
        check("rst_ack", quiesce_ack, 0);
        check("rst_err", err_underflow, 0);
        aresetn = 1'b1;
        step();

        // Fill the write limit with back-to-back AWs and no B.
        s_awvalid = 1'b1; m_awready = 1'b1;
        #1 check("aw1_ready", s_awready, 1);
        repeat (4) step();
        #1;
        check("wr_full", wr_outstanding, 4);
        check("aw_blocked", s_awready, 0);
        check("model_wr_full", m_wr, 4);
        step();
        #1 check("wr_hold", wr_outstanding, 4);
        bvalid = 1'b1; bready = 1'b1;
        step();
        bvalid = 1'b0; bready = 1'b0;
        #1;
        check("wr_after_b", wr_outstanding, 3);
        check("aw5_ready", s_awready, 1);
        step();
        #1 check("wr_aw5", wr_outstanding, 4);

        // Simultaneous increment/decrement at count 2.
        s_awvalid = 1'b0; bvalid = 1'b1; bready = 1'b1;
        repeat (2) step();
        #1 check("wr_two", wr_outstanding, 2);
        s_awvalid = 1'b1;
        step();
        #1 check("wr_simul", wr_outstanding, 2);
        s_awvalid = 1'b0; bvalid = 1'b0; bready = 1'b0;

        // Reads: simultaneous AR + last beat, then an 8-beat burst.
        s_arvalid = 1'b1; m_arready = 1'b1;
        step();
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        step();
        #1 check("rd_simul", rd_outstanding, 1);
        s_arvalid = 1'b0; rlast = 1'b0;
        repeat (7) step();
        #1 check("rd_mid_burst", rd_outstanding, 1);
        rlast = 1'b1;
        step();
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        #1 check("rd_burst_end", rd_outstanding, 0);

        // Drain writes to zero, then one extra B underflows.
        bvalid = 1'b1; bready = 1'b1;
        repeat (2) step();
        #1 check("uf_before", err_underflow, 0);
        step();
        bvalid = 1'b0; bready = 1'b0;
        #1;
        check("uf_cnt", wr_outstanding, 0);
        check("uf_err", err_underflow, 1);
        check("model_uf_err", m_err, 1);
        repeat (100) step();
        #1 check("uf_sticky", err_underflow, 1);
        aresetn = 1'b0;
        #1 check("uf_cleared", err_underflow, 0);
        step();
        aresetn = 1'b1;
        step();

        // Quiesce with 3 writes and 2 reads outstanding.
        s_awvalid = 1'b1; s_arvalid = 1'b1;
        repeat (2) step();
        s_arvalid = 1'b0;
        step();
        s_awvalid = 1'b0;
        #1;
        check("q_wr3", wr_outstanding, 3);
        check("q_rd2", rd_outstanding, 2);
        quiesce_req = 1'b1;
        step();
        s_awvalid = 1'b1; s_arvalid = 1'b1;
        #1;
        check("drain_awready", s_awready, 0);
        check("drain_awvalid", m_awvalid, 0);
        check("drain_arready", s_arready, 0);
        check("drain_arvalid", m_arvalid, 0);
        s_awvalid = 1'b0; s_arvalid = 1'b0;
        bvalid = 1'b1; bready = 1'b1; rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        repeat (2) step();
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        step();
        bvalid = 1'b0; bready = 1'b0;
        #1;
        check("drained_wr", wr_outstanding, 0);
        check("drained_rd", rd_outstanding, 0);
        check("ack_not_yet", quiesce_ack, 0);
        step();
        #1 check("ack_set", quiesce_ack, 1);
        quiesce_req = 1'b0;
        step();
        #1;
        check("ack_clear", quiesce_ack, 0);
        check("reopen_aw", s_awready, 1);

        // Quiesce raised in the same cycle as an AW handshake.
        s_awvalid = 1'b1; quiesce_req = 1'b1;
        #1 check("q_aw_ready", s_awready, 1);
        step();
        s_awvalid = 1'b0;
        #1;
        check("q_aw_counted", wr_outstanding, 1);
        check("q_aw_gated", s_awready, 0);
        repeat (3) step();
        #1 check("q_wait_b", quiesce_ack, 0);
        bvalid = 1'b1; bready = 1'b1;
        step();
        bvalid = 1'b0; bready = 1'b0;
        step();
        #1 check("q_aw_ack", quiesce_ack, 1);
        quiesce_req = 1'b0;
        step();

        // Reset while draining with both counters at the limit.
        s_awvalid = 1'b1; s_arvalid = 1'b1;
        repeat (4) step();
        s_awvalid = 1'b0; s_arvalid = 1'b0; quiesce_req = 1'b1;
        step();
        #1;
        check("pre_rst_wr", wr_outstanding, 4);
        check("pre_rst_rd", rd_outstanding, 4);
        quiesce_req = 1'b0;
        aresetn = 1'b0;
        #1;
        check("mid_rst_wr", wr_outstanding, 0);
        check("mid_rst_rd", rd_outstanding, 0);
        check("mid_rst_ack", quiesce_ack, 0);
        check("mid_rst_run", s_awready, 1);
        step();
        aresetn = 1'b1;
        s_awvalid = 1'b1;
        #1 check("post_rst_aw", s_awready, 1);
        step();
        s_awvalid = 1'b0;
        #1 check("post_rst_wr", wr_outstanding, 1);

        // Randomized traffic in phases that favour filling, draining or balance.
        for (int i = 0; i < 4000; i++) begin
            ph = (i / 300) % 4;
            case (ph)
                0:       begin pa = 80; pb = 20; end
                1:       begin pa = 20; pb = 70; end
                default: begin pa = 50; pb = 50; end
            endcase
            pr = 100 - pb;
            step();
            if (!aresetn) aresetn = 1'b1;
            else if ($urandom_range(0, 999) < 3) aresetn = 1'b0;
            s_awvalid = ($urandom_range(0, 99) < pa);
            m_awready = ($urandom_range(0, 99) < 75);
            s_arvalid = ($urandom_range(0, 99) < pa);
            m_arready = ($urandom_range(0, 99) < 75);
            bvalid    = ($urandom_range(0, 99) < pb);
            bready    = ($urandom_range(0, 99) < 80);
            rvalid    = ($urandom_range(0, 99) < pr);
            rready    = ($urandom_range(0, 99) < 80);
            rlast     = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 99) < 4) quiesce_req = ~quiesce_req;
        end

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
